spi_adc_capturer: RTL and testbench



---
 rtl/audio_pkg.sv | 20 ++
 rtl/spi_shift_lane.sv | 25 ++
 rtl/spi_adc_capturer.sv | 164 ++++++++++++++++
 tb/tb_spi_adc_capturer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-capture definitions: default rates, SPI capture FSM encoding and
// the offset-binary to two's-complement helper.
package audio_pkg;

   localparam int unsigned DEFAULT_CLK_HZ    = 100_000_000;
   localparam int unsigned DEFAULT_SAMPLE_HZ = 20_000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } cap_state_t;

   // Flipping the MSB maps offset binary (mid-scale = 100..0) onto two's complement.
   function automatic logic [31:0] offset_to_signed(input logic [31:0] value,
                                                    input int unsigned width);
      return value ^ (32'd1 << (width - 1));
   endfunction

endpackage

// File: rtl/spi_shift_lane.sv
// One MISO lane: FRAME_BITS shift register filled MSB-first, exposing the last
// DATA_W bits received.
module spi_shift_lane #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned DATA_W     = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clear,
   input  logic              shift,
   input  logic              din,
   output logic [DATA_W-1:0] capture
);

   logic [FRAME_BITS-1:0] bits;

   // NOTE: the shift bits are reset like any other state so an aborted frame leaves nothing stale.
   always_ff @(posedge CLK) begin
      if (RST || clear) bits <= '0;
      else if (shift)   bits <= (bits << 1) | FRAME_BITS'(din);
   end

   assign capture = bits[DATA_W-1:0];

endmodule

// File: rtl/spi_adc_capturer.sv
// SPI ADC frame generator and N_CH-lane deserialiser; cs/sclk are plain CLK-domain
// registers and every lane is sampled on the CLK edge that drops sclk.
module spi_adc_capturer
   import audio_pkg::*;
#(
   parameter int unsigned CLK_HZ     = DEFAULT_CLK_HZ,
   parameter int unsigned SAMPLE_HZ  = DEFAULT_SAMPLE_HZ,
   parameter int unsigned SCLK_DIV   = 50,
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned DISP_W     = 10,
   parameter int unsigned N_CH       = 1,
   parameter int unsigned SIGNED_OUT = 0
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     en,
   input  logic [N_CH-1:0]          MISO,
   output logic                     cs,
   output logic                     sclk,
   output logic [N_CH*DATA_W-1:0]   sample,
   output logic [N_CH*DISP_W-1:0]   display_sample,
   output logic                     sample_valid,
   output logic                     busy
);

   localparam int unsigned PERIOD  = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned TOGGLES = 2 * FRAME_BITS;
   localparam int unsigned PCNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned HCNT_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int unsigned TCNT_W  = $clog2(TOGGLES + 1);

   generate
      if (PERIOD < TOGGLES * SCLK_DIV + 2) begin : g_bad_period
         $error("spi_adc_capturer: PERIOD too short to fit one frame");
      end
      if (DATA_W > FRAME_BITS) begin : g_bad_data_w
         $error("spi_adc_capturer: DATA_W exceeds FRAME_BITS");
      end
      if (DISP_W > DATA_W) begin : g_bad_disp_w
         $error("spi_adc_capturer: DISP_W exceeds DATA_W");
      end
      if (SCLK_DIV < 1) begin : g_bad_div
         $error("spi_adc_capturer: SCLK_DIV must be at least 1");
      end
   endgenerate

   cap_state_t        state, state_next;
   logic [PCNT_W-1:0] pcnt;
   logic [HCNT_W-1:0] hcnt;
   logic [TCNT_W-1:0] tcnt;
   logic              half_done, toggle, last_toggle;
   logic              start, fall, latch;

   assign half_done   = (hcnt == HCNT_W'(SCLK_DIV - 1));
   assign toggle      = (state == SHIFT) && half_done;
   assign last_toggle = toggle && (tcnt == TCNT_W'(TOGGLES - 1));

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: the default assignment first keeps this block purely combinational (no latch).
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (en && (pcnt == '0)) state_next = SHIFT;
         SHIFT:   if (last_toggle)        state_next = LATCH;
         LATCH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      start = 1'b0;
      fall  = 1'b0;
      latch = 1'b0;
      case (state)
         IDLE:    start = en && (pcnt == '0);
         SHIFT:   fall  = toggle && sclk;
         LATCH:   latch = 1'b1;
         default: ;
      endcase
   end

   // Frame timebase; parking it at 0 while disabled makes a frame start on the first enabled edge.
   always_ff @(posedge CLK) begin
      if (RST || !en)                        pcnt <= '0;
      else if (pcnt == PCNT_W'(PERIOD - 1))  pcnt <= '0;
      else                                   pcnt <= pcnt + PCNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cs   <= 1'b1;
         sclk <= 1'b0;
         hcnt <= '0;
         tcnt <= '0;
      end else if (start) begin
         cs   <= 1'b0;
         sclk <= 1'b0;
         hcnt <= '0;
         tcnt <= '0;
      end else if (state == SHIFT) begin
         if (half_done) begin
            hcnt <= '0;
            sclk <= ~sclk;
            tcnt <= tcnt + TCNT_W'(1);
         end else begin
            hcnt <= hcnt + HCNT_W'(1);
         end
      end else if (latch) begin
         cs <= 1'b1;
      end
   end

   logic [N_CH*DATA_W-1:0] captured;
   logic [N_CH*DATA_W-1:0] converted;
   logic [N_CH*DISP_W-1:0] display_next;

   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      spi_shift_lane #(
         .FRAME_BITS(FRAME_BITS),
         .DATA_W    (DATA_W)
      ) u_lane (
         .CLK    (CLK),
         .RST    (RST),
         .clear  (start),
         .shift  (fall),
         .din    (MISO[i]),
         .capture(captured[i*DATA_W +: DATA_W])
      );
   end

   always_comb begin
      converted    = captured;
      display_next = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (SIGNED_OUT != 0)
            converted[i*DATA_W +: DATA_W] =
               DATA_W'(offset_to_signed(32'(captured[i*DATA_W +: DATA_W]), DATA_W));
         display_next[i*DISP_W +: DISP_W] = converted[i*DATA_W + DATA_W - DISP_W +: DISP_W];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sample         <= '0;
         display_sample <= '0;
         sample_valid   <= 1'b0;
      end else begin
         sample_valid <= latch;
         if (latch) begin
            sample         <= converted;
            display_sample <= display_next;
         end
      end
   end

   assign busy = ~cs;

endmodule

// File: tb/tb_spi_adc_capturer.sv
// Directed bench for spi_adc_capturer: default, signed-output and two-lane instances
// run in lockstep from shared CLK/RST/en with per-instance MISO frames.
module tb_spi_adc_capturer;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic en  = 1'b0;

   logic        miso0 = 1'b0, misos = 1'b0;
   logic [1:0]  miso2 = 2'b00;
   logic        cs0, sclk0, valid0, busy0;
   logic        css, sclks, valids, busys;
   logic        cs2, sclk2, valid2, busy2;
   logic [11:0] smp0, smps;
   logic [9:0]  dsp0, dsps;
   logic [23:0] smp2;
   logic [19:0] dsp2;

   always #5 CLK = ~CLK;

   spi_adc_capturer dut0 (
      .CLK(CLK), .RST(RST), .en(en), .MISO(miso0),
      .cs(cs0), .sclk(sclk0), .sample(smp0), .display_sample(dsp0),
      .sample_valid(valid0), .busy(busy0)
   );

   spi_adc_capturer #(.SIGNED_OUT(1)) dut_s (
      .CLK(CLK), .RST(RST), .en(en), .MISO(misos),
      .cs(css), .sclk(sclks), .sample(smps), .display_sample(dsps),
      .sample_valid(valids), .busy(busys)
   );

   spi_adc_capturer #(.N_CH(2)) dut2 (
      .CLK(CLK), .RST(RST), .en(en), .MISO(miso2),
      .cs(cs2), .sclk(sclk2), .sample(smp2), .display_sample(dsp2),
      .sample_valid(valid2), .busy(busy2)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Per-frame observations filled in by run_frame.
   int          t0_cyc, valid_off, nvalid, nfall, bad_phase, cs_low_cnt;
   int          idle_bad = 0;
   logic        cs_at_valid, vs_at, v2_at;
   logic [11:0] s0_v, ss_v, s0_end;
   logic [9:0]  d0_v, ds_v;
   logic [23:0] s2_v;
   logic [19:0] d2_v;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic drive_bits(input logic [15:0] f0, input logic [15:0] fs,
                             input logic [15:0] fa, input logic [15:0] fb, input int idx);
      miso0 = f0[15-idx];
      misos = fs[15-idx];
      miso2 = {fb[15-idx], fa[15-idx]};
   endtask

   // Waits for cs low, feeds one 16-bit frame per DUT MSB-first (next bit presented
   // right after each sclk fall) and records timing and captured values.
   task automatic run_frame(input logic [15:0] f0, input logic [15:0] fs,
                            input logic [15:0] fa, input logic [15:0] fb,
                            input int rst_at, input int en_off_at);
      int   k, last_t, idx, k_end;
      logic prev;
      nvalid = 0; nfall = 0; bad_phase = 0; valid_off = -1; t0_cyc = -1;
      cs_at_valid = 1'b0; vs_at = 1'b0; v2_at = 1'b0;
      k = 0;
      while (cs0 !== 1'b0 && k < 6000) begin
         if (sclk0 !== 1'b0) idle_bad++;
         tick();
         k++;
      end
      if (cs0 !== 1'b0) begin
         check("cs_fall_timeout", {63'd0, cs0}, 64'd0);
         return;
      end
      t0_cyc = cyc;
      idx    = 0;
      last_t = 0;
      prev   = sclk0;
      drive_bits(f0, fs, fa, fb, idx);
      k_end = (rst_at > 0) ? rst_at + 1 : 1700;
      for (k = 1; k <= k_end; k++) begin
         tick();
         if (sclk0 !== prev) begin
            if (k - last_t != 50) bad_phase++;
            last_t = k;
            if (prev === 1'b1) begin
               nfall++;
               idx++;
               if (idx < 16) drive_bits(f0, fs, fa, fb, idx);
            end
            prev = sclk0;
         end
         if (cs0 === 1'b1 && sclk0 !== 1'b0) idle_bad++;
         if (valid0 === 1'b1) begin
            nvalid++;
            if (valid_off < 0) begin
               valid_off   = k;
               cs_at_valid = cs0;
               vs_at = valids; v2_at = valid2;
               s0_v = smp0; d0_v = dsp0; ss_v = smps; ds_v = dsps;
               s2_v = smp2; d2_v = dsp2;
            end
         end
         if (rst_at > 0 && k == rst_at + 1) begin
            RST = 1'b0;
            check("rst_cs",   {63'd0, cs0},   64'd1);
            check("rst_sclk", {63'd0, sclk0}, 64'd0);
            check("rst_busy", {63'd0, busy0}, 64'd0);
         end
         if (rst_at > 0 && k == rst_at) RST = 1'b1;
         if (k == en_off_at) en = 1'b0;
      end
      s0_end = smp0;
   endtask

   int t_prev;

   initial begin
      // Reset state with en low.
      repeat (3) tick();
      check("reset_cs",      {63'd0, cs0},    64'd1);
      check("reset_sclk",    {63'd0, sclk0},  64'd0);
      check("reset_busy",    {63'd0, busy0},  64'd0);
      check("reset_valid",   {63'd0, valid0}, 64'd0);
      check("reset_sample",  64'(smp0),       64'd0);
      check("reset_display", 64'(dsp0),       64'd0);
      check("reset_sample2", 64'(smp2),       64'd0);
      RST = 1'b0;
      tick();
      check("idle_without_en", {63'd0, cs0}, 64'd1);
      en = 1'b1;

      // Frame aborted by a one-cycle RST at t0+800.
      run_frame(16'h0123, 16'h0123, 16'h0123, 16'h0123, 800, 0);
      check("abort_no_valid", 64'(nvalid), 64'd0);
      check("abort_sample0",  64'(smp0),   64'd0);
      check("abort_samples",  64'(smps),   64'd0);
      check("abort_sample2",  64'(smp2),   64'd0);

      // Frame B: reference pattern, 0x800 signed, two-lane pattern.
      run_frame(16'h0AC3, 16'h0800, 16'h0123, 16'h0FED, 0, 0);
      t_prev = t0_cyc;
      check("b_valid_time",  64'(valid_off),     64'd1601);
      check("b_valid_width", 64'(nvalid),        64'd1);
      check("b_cs_at_valid", {63'd0, cs_at_valid}, 64'd1);
      check("b_falls",       64'(nfall),         64'd16);
      check("b_sclk_phase",  64'(bad_phase),     64'd0);
      check("b_sample0",     64'(s0_v),          64'hAC3);
      check("b_display0",    64'(d0_v),          64'h2B0);
      check("b_hold0",       64'(s0_end),        64'hAC3);
      check("b_valid_s",     {63'd0, vs_at},     64'd1);
      check("b_sample_s",    64'(ss_v),          64'h000);
      check("b_display_s",   64'(ds_v),          64'h000);
      check("b_valid_2",     {63'd0, v2_at},     64'd1);
      check("b_sample2",     64'(s2_v),          64'hFED123);
      check("b_display2",    64'(d2_v),          64'(20'hFEC48));

      // Frame C.
      run_frame(16'hF555, 16'h0000, 16'h0FFF, 16'h0000, 0, 0);
      check("c_period",      64'(t0_cyc - t_prev), 64'd5000);
      t_prev = t0_cyc;
      check("c_falls",       64'(nfall),     64'd16);
      check("c_sclk_phase",  64'(bad_phase), 64'd0);
      check("c_sample0",     64'(s0_v),      64'h555);
      check("c_display0",    64'(d0_v),      64'h155);
      check("c_sample_s",    64'(ss_v),      64'h800);
      check("c_display_s",   64'(ds_v),      64'h200);
      check("c_sample2",     64'(s2_v),      64'h000FFF);
      check("c_display2",    64'(d2_v),      64'h003FF);

      // Frame D.
      run_frame(16'h0000, 16'h0FFF, 16'h0000, 16'h0FFF, 0, 0);
      check("d_period",      64'(t0_cyc - t_prev), 64'd5000);
      t_prev = t0_cyc;
      check("d_falls",       64'(nfall),     64'd16);
      check("d_sclk_phase",  64'(bad_phase), 64'd0);
      check("d_sample0",     64'(s0_v),      64'h000);
      check("d_sample_s",    64'(ss_v),      64'h7FF);
      check("d_display_s",   64'(ds_v),      64'h1FF);
      check("d_sample2",     64'(s2_v),      64'hFFF000);
      check("d_display2",    64'(d2_v),      64'hFFC00);

      // Frame E: en dropped at t0+400, frame still completes.
      run_frame(16'h0FFF, 16'h0800, 16'h0001, 16'h0001, 0, 400);
      check("e_period",      64'(t0_cyc - t_prev), 64'd5000);
      check("e_valid_time",  64'(valid_off), 64'd1601);
      check("e_valid_width", 64'(nvalid),    64'd1);
      check("e_sample0",     64'(s0_v),      64'hFFF);
      check("e_display0",    64'(d0_v),      64'h3FF);

      // With en low no frame may start, even across a full period.
      cs_low_cnt = 0;
      for (int i = 0; i < 6000; i++) begin
         tick();
         if (cs0 !== 1'b1) cs_low_cnt++;
         if (cs0 === 1'b1 && sclk0 !== 1'b0) idle_bad++;
      end
      check("en_low_cs_held", 64'(cs_low_cnt), 64'd0);
      en = 1'b1;
      tick();
      check("en_return_cs", {63'd0, cs0}, 64'd0);

      // Frame F after en returns.
      run_frame(16'h0123, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      check("f_valid_time",  64'(valid_off), 64'd1601);
      check("f_sample0",     64'(s0_v),      64'h123);
      check("f_display0",    64'(d0_v),      64'h048);

      check("sclk_idle_low", 64'(idle_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
